// File: rtl/controle_pkg.sv
// Shared constants for the multi-cycle calculator control unit:
// opcode map, one-hot ULA codes, FSM state encoding and error codes.
package controle_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_MCLR = 3'b100;
    localparam logic [2:0] OP_ILL  = 3'b101;
    localparam logic [2:0] OP_MRD  = 3'b110;
    localparam logic [2:0] OP_MWR  = 3'b111;

    localparam logic [3:0] ULA_NONE = 4'b0000;
    localparam logic [3:0] ULA_ADD  = 4'b1000;
    localparam logic [3:0] ULA_SUB  = 4'b0100;
    localparam logic [3:0] ULA_MUL  = 4'b0010;
    localparam logic [3:0] ULA_DIV  = 4'b0001;

    localparam logic [2:0] MEM_NONE = 3'b000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_WAIT_ULA = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    // One-hot ULA selector; memory and illegal opcodes leave the ULA idle.
    function automatic logic [3:0] ula_onehot(input logic [2:0] op);
        logic [3:0] code;
        case (op)
            OP_ADD:  code = ULA_ADD;
            OP_SUB:  code = ULA_SUB;
            OP_MUL:  code = ULA_MUL;
            OP_DIV:  code = ULA_DIV;
            default: code = ULA_NONE;
        endcase
        return code;
    endfunction

    // Memory opcodes all have the MSB set; 101 shares that bit but is illegal.
    function automatic logic is_mem_op(input logic [2:0] op);
        return op[2] && (op != OP_ILL);
    endfunction

endpackage

// File: rtl/controle_watchdog.sv
// Handshake watchdog: counts cycles spent in a wait state and flags the
// cycle in which the TIMEOUT-th consecutive wait cycle is reached.
module controle_watchdog
    import controle_pkg::*;
#(
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // cnt_q holds the number of wait cycles already completed, so the
    // current wait cycle is cnt_q+1; it saturates at TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle calculator control unit. Accepts one instruction per
// valid/ready handshake, decodes it, sequences the ULA (single-cycle
// add/sub, handshaked mul/div) or data memory, pulses register write-back
// and traps on illegal opcodes or handshake timeouts. All outputs are
// registered and derived from the next state.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int OP_W       = 3,
    parameter int REG_ADDR_W = 2,
    parameter int TIMEOUT    = 16,
    localparam int IMM_W     = INSTR_W - OP_W - 2*REG_ADDR_W
) (
    input  logic                  _clock,
    input  logic                  _reset,
    input  logic [INSTR_W-1:0]    _instrucao,
    input  logic                  _instr_valid,
    output logic                  _instr_ready,
    output logic [3:0]            _ula_op,
    output logic                  _ula_start,
    input  logic                  _ula_done,
    output logic [2:0]            _mem_control,
    output logic                  _mem_req,
    input  logic                  _mem_ack,
    output logic [REG_ADDR_W-1:0] _reg_dest,
    output logic [IMM_W-1:0]      _imediato,
    output logic                  _reg_write,
    output logic                  _busy,
    output logic                  _erro,
    output logic [1:0]            _erro_codigo
);

    state_t                state_q, state_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;

    logic                  instr_ready_q, instr_ready_d;
    logic [3:0]            ula_op_q, ula_op_d;
    logic                  ula_start_q, ula_start_d;
    logic [2:0]            mem_control_q, mem_control_d;
    logic                  mem_req_q, mem_req_d;
    logic [REG_ADDR_W-1:0] reg_dest_q, reg_dest_d;
    logic [IMM_W-1:0]      imediato_q, imediato_d;
    logic                  reg_write_q, reg_write_d;
    logic                  busy_q, busy_d;
    logic                  erro_q, erro_d;
    logic [1:0]            erro_codigo_q, erro_codigo_d;

    logic                  wd_clear, wd_enable, wd_expired;

    // Instruction fields, taken from the latched word.
    logic [OP_W-1:0]       f_op;
    logic [REG_ADDR_W-1:0] f_reg_a;
    logic [REG_ADDR_W-1:0] f_dest;
    logic [IMM_W-1:0]      f_imm;

    assign f_op    = instr_q[INSTR_W-1 -: OP_W];
    assign f_reg_a = instr_q[INSTR_W-OP_W-1 -: REG_ADDR_W];
    assign f_dest  = instr_q[INSTR_W-OP_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign f_imm   = instr_q[IMM_W-1:0];

    // Watchdog restarts on every pass through decode and runs only in the
    // two handshake wait states.
    assign wd_clear  = (state_q == S_DECODE);
    assign wd_enable = (state_q == S_WAIT_ULA) || (state_q == S_MEM);

    controle_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (_clock),
        .rst     (_reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        ula_op_d      = ula_op_q;
        mem_control_d = mem_control_q;
        reg_dest_d    = reg_dest_q;
        imediato_d    = imediato_q;
        erro_codigo_d = erro_codigo_q;

        case (state_q)
            S_IDLE: begin
                if (_instr_valid) begin
                    instr_d = _instrucao;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ula_op_d      = ula_onehot(f_op);
                mem_control_d = is_mem_op(f_op) ? f_op : MEM_NONE;
                reg_dest_d    = (f_op == OP_MRD) ? f_dest : f_reg_a;
                imediato_d    = f_imm;
                case (f_op)
                    OP_ADD, OP_SUB:           state_d = S_EXEC;
                    OP_MUL, OP_DIV:           state_d = S_WAIT_ULA;
                    OP_MCLR, OP_MRD, OP_MWR:  state_d = S_MEM;
                    default: begin
                        state_d       = S_TRAP;
                        erro_codigo_d = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WAIT_ULA: begin
                // A done arriving on the expiry cycle still completes normally.
                if (_ula_done) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    state_d       = S_TRAP;
                    erro_codigo_d = ERR_TIMEOUT;
                end
            end
            S_MEM: begin
                if (_mem_ack) begin
                    state_d = (f_op == OP_MRD) ? S_WB : S_IDLE;
                end else if (wd_expired) begin
                    state_d       = S_TRAP;
                    erro_codigo_d = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status and strobes follow the state being entered.
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        erro_d        = (state_d == S_TRAP);
        reg_write_d   = (state_d == S_WB);
        mem_req_d     = (state_d == S_MEM);
        ula_start_d   = (state_q == S_DECODE) && (state_d == S_WAIT_ULA);
    end

    // FSM state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            instr_ready_q <= 1'b1;
            ula_op_q      <= ULA_NONE;
            ula_start_q   <= 1'b0;
            mem_control_q <= MEM_NONE;
            mem_req_q     <= 1'b0;
            reg_dest_q    <= '0;
            imediato_q    <= '0;
            reg_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            erro_q        <= 1'b0;
            erro_codigo_q <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            ula_op_q      <= ula_op_d;
            ula_start_q   <= ula_start_d;
            mem_control_q <= mem_control_d;
            mem_req_q     <= mem_req_d;
            reg_dest_q    <= reg_dest_d;
            imediato_q    <= imediato_d;
            reg_write_q   <= reg_write_d;
            busy_q        <= busy_d;
            erro_q        <= erro_d;
            erro_codigo_q <= erro_codigo_d;
        end
    end

    assign _instr_ready = instr_ready_q;
    assign _ula_op      = ula_op_q;
    assign _ula_start   = ula_start_q;
    assign _mem_control = mem_control_q;
    assign _mem_req     = mem_req_q;
    assign _reg_dest    = reg_dest_q;
    assign _imediato    = imediato_q;
    assign _reg_write   = reg_write_q;
    assign _busy        = busy_q;
    assign _erro        = erro_q;
    assign _erro_codigo = erro_codigo_q;

endmodule
